// File: rtl/serial_sum_deserializer_if.sv
// Handshake bundle between the serial adder side, the deserializer and the
// word consumer. The master side drives the strobes and the ready; the slave
// side (the deserializer) returns the assembled word and status.
interface serial_sum_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             clr;
  logic             bit_en;
  logic             s_in;
  logic             cout_in;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             sum_valid;
  logic             sum_ready;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output clr, bit_en, s_in, cout_in, sum_ready,
    input  sum, carry, sum_valid, overrun, bit_cnt
  );

  modport slave (
    input  clr, bit_en, s_in, cout_in, sum_ready,
    output sum, carry, sum_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/serial_sum_deserializer.sv
// Collects the LSB-first serial sum stream plus the final carry into a
// parallel word and offers it on a valid/ready handshake. A strobe that
// arrives while a finished word is still waiting is dropped and latches a
// sticky overrun flag.
module serial_sum_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    NRST,
  serial_sum_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_sum_valid;
  logic             r_overrun;
  logic [CW-1:0]    r_bit_cnt;

  // Next word contents after accepting the current strobe bit
  logic [WIDTH-1:0] w_shifted;
  assign w_shifted = {bus.s_in, r_sum[WIDTH-1:1]};

  // Deserializer FSM: all outputs are registered alongside the state, so
  // sum_valid has no combinational path from the inputs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_sum_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_bit_cnt   <= '0;
    end else if (bus.clr) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_sum_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.bit_en) begin
            r_sum     <= w_shifted;
            r_bit_cnt <= ONE;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.bit_en) begin
            r_sum     <= w_shifted;
            r_bit_cnt <= r_bit_cnt + ONE;
            if (r_bit_cnt == LAST_IDX) begin
              r_carry     <= bus.cout_in;
              r_sum_valid <= 1'b1;
              r_state     <= FULL;
            end
          end
        end
        FULL: begin
          if (bus.sum_ready) begin
            r_sum_valid <= 1'b0;
            if (bus.bit_en) begin
              r_sum     <= w_shifted;
              r_bit_cnt <= ONE;
              r_state   <= SHIFT;
            end else begin
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end
          end else if (bus.bit_en) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sum_valid <= 1'b0;
          r_bit_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;
  assign bus.sum_valid = r_sum_valid;
  assign bus.overrun   = r_overrun;
  assign bus.bit_cnt   = r_bit_cnt;
endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Directed bench for serial_sum_deserializer. Expected words are queued when
// their strobes are driven and compared when the DUT hands them over.
module tb_serial_sum_deserializer;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic CLK;
  logic NRST;

  serial_sum_deserializer_if #(.WIDTH(WIDTH)) ifc ();

  serial_sum_deserializer #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (ifc.slave)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;
  int validCycles = 0;

  logic [WIDTH:0] expQ[$];
  int             xferCycles[$];

  // Free-running clock, 10 time units per period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle counter used to measure spacing between transfers
  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a handshake is seen at the falling edge before the
  // transferring rising edge
  always @(negedge CLK) begin
    if (NRST && ifc.sum_valid) validCycles++;
    if (NRST && !ifc.clr && ifc.sum_valid && ifc.sum_ready) begin
      xferCycles.push_back(cycle);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 64'({ifc.carry, ifc.sum}), 64'h1_0000_0000);
      end else begin
        checkOutput("word", 64'({ifc.carry, ifc.sum}), 64'(expQ.pop_front()));
      end
    end
  end

  // One strobe, driven just after a rising edge and held for one cycle
  task automatic applyStimulus(input logic s, input logic c);
    ifc.bit_en  = 1'b1;
    ifc.s_in    = s;
    ifc.cout_in = c;
    @(posedge CLK); #1;
  endtask

  // A full word of strobes, LSB first; cout only meaningful on the last bit
  task automatic sendWord(input logic [WIDTH-1:0] data, input logic c, input bit push);
    if (push) expQ.push_back({c, data});
    for (int i = 0; i < WIDTH; i++)
      applyStimulus(data[i], (i == WIDTH - 1) ? c : ~c);
  endtask

  task automatic idleCycles(input int n);
    ifc.bit_en = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    int k;
    k = 0;
    while (expQ.size() != 0 && k < maxCycles) begin
      @(posedge CLK); #1;
      k++;
    end
    checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
  endtask

  // Directed test sequence
  initial begin
    int c0;
    NRST          = 1'b0;
    ifc.clr       = 1'b0;
    ifc.bit_en    = 1'b0;
    ifc.s_in      = 1'b0;
    ifc.cout_in   = 1'b0;
    ifc.sum_ready = 1'b0;
    #23;
    checkOutput("reset_valid", 64'(ifc.sum_valid), 64'd0);
    checkOutput("reset_cnt", 64'(ifc.bit_cnt), 64'd0);
    checkOutput("reset_sum", 64'(ifc.sum), 64'd0);
    NRST = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] T1 single word 0x96");
    ifc.sum_ready = 1'b1;
    validCycles = 0;
    sendWord(8'h96, 1'b0, 1'b1);
    idleCycles(4);
    waitDrain(20);
    checkOutput("t1_valid_pulse", 64'(validCycles), 64'd1);
    checkOutput("t1_cnt_idle", 64'(ifc.bit_cnt), 64'd0);

    $display("[TB] T2 held word 0xFF carry 1");
    ifc.sum_ready = 1'b0;
    sendWord(8'hFF, 1'b1, 1'b1);
    ifc.bit_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_valid", 64'(ifc.sum_valid), 64'd1);
      checkOutput("t2_hold_cnt", 64'(ifc.bit_cnt), 64'(WIDTH));
      @(posedge CLK); #1;
    end
    ifc.sum_ready = 1'b1;
    @(posedge CLK); #1;
    checkOutput("t2_after_valid", 64'(ifc.sum_valid), 64'd0);
    checkOutput("t2_after_cnt", 64'(ifc.bit_cnt), 64'd0);
    waitDrain(5);

    $display("[TB] T3 overrun then clr");
    ifc.sum_ready = 1'b0;
    sendWord(8'h3C, 1'b0, 1'b1);
    checkOutput("t3_pre_overrun", 64'(ifc.overrun), 64'd0);
    applyStimulus(1'b1, 1'b1);
    ifc.bit_en = 1'b0;
    checkOutput("t3_overrun", 64'(ifc.overrun), 64'd1);
    checkOutput("t3_sum_kept", 64'({ifc.carry, ifc.sum}), 64'h03C);
    checkOutput("t3_cnt_kept", 64'(ifc.bit_cnt), 64'(WIDTH));
    idleCycles(3);
    checkOutput("t3_overrun_sticky", 64'(ifc.overrun), 64'd1);
    ifc.clr = 1'b1;
    @(posedge CLK); #1;
    ifc.clr = 1'b0;
    expQ.delete();
    checkOutput("t3_clr_overrun", 64'(ifc.overrun), 64'd0);
    checkOutput("t3_clr_valid", 64'(ifc.sum_valid), 64'd0);
    checkOutput("t3_clr_cnt", 64'(ifc.bit_cnt), 64'd0);
    checkOutput("t3_clr_sum", 64'({ifc.carry, ifc.sum}), 64'd0);

    $display("[TB] T4 handshake with simultaneous strobe");
    sendWord(8'hC3, 1'b1, 1'b1);
    ifc.sum_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    expQ.push_back({1'b0, 8'h01});
    checkOutput("t4_cnt", 64'(ifc.bit_cnt), 64'd1);
    checkOutput("t4_valid", 64'(ifc.sum_valid), 64'd0);
    checkOutput("t4_overrun", 64'(ifc.overrun), 64'd0);
    for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b0, (i == WIDTH - 2) ? 1'b0 : 1'b1);
    ifc.bit_en = 1'b0;
    checkOutput("t4_sum", 64'(ifc.sum), 64'h01);
    waitDrain(10);

    $display("[TB] T5 async reset mid-word");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    ifc.bit_en = 1'b0;
    #2 NRST = 1'b0;
    #1;
    checkOutput("t5_rst_sum", 64'(ifc.sum), 64'd0);
    checkOutput("t5_rst_cnt", 64'(ifc.bit_cnt), 64'd0);
    checkOutput("t5_rst_flags", 64'({ifc.carry, ifc.sum_valid, ifc.overrun}), 64'd0);
    #3 NRST = 1'b1;
    @(posedge CLK); #1;
    sendWord(8'hA5, 1'b0, 1'b1);
    ifc.bit_en = 1'b0;
    waitDrain(10);

    $display("[TB] T6 back-to-back words");
    xferCycles.delete();
    validCycles = 0;
    sendWord(8'h12, 1'b0, 1'b1);
    sendWord(8'h34, 1'b1, 1'b1);
    sendWord(8'h56, 1'b0, 1'b1);
    ifc.bit_en = 1'b0;
    waitDrain(20);
    checkOutput("t6_xfers", 64'(xferCycles.size()), 64'd3);
    checkOutput("t6_valid_cycles", 64'(validCycles), 64'd3);
    if (xferCycles.size() == 3) begin
      c0 = xferCycles[1] - xferCycles[0];
      checkOutput("t6_gap1", 64'(c0), 64'd8);
      c0 = xferCycles[2] - xferCycles[1];
      checkOutput("t6_gap2", 64'(c0), 64'd8);
    end
    checkOutput("t6_overrun", 64'(ifc.overrun), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
